// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start-bit qualification, LSB-first payload, optional parity, 1-2 stop bits.
// Define UART_RX_SYNC_EN to pass the RX line through a 2-flop synchroniser (adds 2 cycles of latency).
module uart_rx_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_PER_BIT = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signal,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] C_LAST      = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD_PAR     = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic f_parity_fail(input logic [DATA_WIDTH-1:0] payload,
                                         input logic                  pbit,
                                         input logic                  odd);
    return (((^payload) ^ pbit) != odd);
  endfunction

  logic w_line;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_perr_acc;
  logic                  r_ferr_acc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_perr;
  logic                  r_ferr;
  logic                  r_ready;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [BW-1:0]         w_bit_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_perr_acc_nxt;
  logic                  w_ferr_acc_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_perr_nxt;
  logic                  w_ferr_nxt;
  logic                  w_tick;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchroniser, reset to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], signal};
    end
  end

  assign w_line = r_sync[1];
`else
  assign w_line = signal;
`endif

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_perr_acc <= w_perr_acc_nxt;
      r_ferr_acc <= w_ferr_acc_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_perr     <= w_perr_nxt;
      r_ferr     <= w_ferr_nxt;
      r_ready    <= (w_state_nxt == IDLE);
    end
  end

  // Next-state and datapath decode; the bit-period counter restarts at every sample point
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_perr_acc_nxt = r_perr_acc;
    w_ferr_acc_nxt = r_ferr_acc;
    w_data_nxt     = r_data;
    w_valid_nxt    = 1'b0;
    w_perr_nxt     = 1'b0;
    w_ferr_nxt     = 1'b0;
    w_tick         = (r_cnt == C_LAST);

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_line) begin
          w_state_nxt    = START;
          w_perr_acc_nxt = 1'b0;
          w_ferr_acc_nxt = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_line ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      DATA: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_line, r_shift[DATA_WIDTH-1:1]};
          if (r_bit == B_DATA_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY_MODE == 0) ? STOP : PARITY;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      PARITY: begin
        if (w_tick) begin
          w_cnt_nxt      = '0;
          w_perr_acc_nxt = f_parity_fail(r_shift, w_line, ODD_PAR);
          w_state_nxt    = STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      STOP: begin
        if (w_tick) begin
          w_cnt_nxt      = '0;
          w_ferr_acc_nxt = r_ferr_acc | ~w_line;
          if (r_bit == B_STOP_LAST) begin
            // Leave mid-stop-bit so a back-to-back start edge is seen in IDLE
            w_bit_nxt   = '0;
            w_state_nxt = IDLE;
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_perr_nxt  = r_perr_acc;
            w_ferr_nxt  = r_ferr_acc | ~w_line;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign ready      = r_ready;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: five configurations, directed frames plus random frames
// compared against a frame-level reference model (payload, error flags and delivery cycle).
module tb_uart_rx_core;

  localparam int NI = 5;
  localparam int P_DW  [NI] = '{8, 8, 8, 5, 7};
  localparam int P_CPB [NI] = '{16, 16, 16, 16, 5};
  localparam int P_PAR [NI] = '{0, 1, 0, 0, 2};
  localparam int P_STP [NI] = '{1, 1, 2, 1, 2};
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int          inst;
    logic [15:0] data;
    logic        perr;
    logic        ferr;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line    [NI];
  logic [15:0] w_data  [NI];
  logic        w_valid [NI];
  logic        w_ready [NI];
  logic        w_perr  [NI];
  logic        w_ferr  [NI];

  int  cyc = 0;
  int  rdy_low [NI];
  ev_t mon_q[$];
  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [P_DW[g]-1:0] d;
    uart_rx_core #(
      .DATA_WIDTH (P_DW[g]),
      .CLK_PER_BIT(P_CPB[g]),
      .PARITY_MODE(P_PAR[g]),
      .STOP_BITS  (P_STP[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .signal    (line[g]),
      .data      (d),
      .valid     (w_valid[g]),
      .ready     (w_ready[g]),
      .parity_err(w_perr[g]),
      .frame_err (w_ferr[g])
    );
    assign w_data[g] = 16'(d);
  end

  // Record every valid pulse and count not-ready cycles per instance
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (w_valid[k] === 1'b1) mon_q.push_back('{k, w_data[k], w_perr[k], w_ferr[k], cyc});
      if (w_ready[k] !== 1'b1) rdy_low[k] <= rdy_low[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on instance k (entered on a negedge) and queue the expected delivery.
  task automatic send_frame(input int k, input logic [15:0] pay, input logic pbit,
                            input logic [1:0] stops, input int gap);
    logic [39:0] fr;
    logic [15:0] p;
    logic        perr;
    logic        ferr;
    int          nb;
    int          cpb;
    int          g2;
    int          c0;
    cpb  = P_CPB[k];
    p    = pay & 16'((32'd1 << P_DW[k]) - 32'd1);
    fr   = '0;
    nb   = 1;
    perr = 1'b0;
    ferr = 1'b0;
    for (int i = 0; i < P_DW[k]; i++) begin
      fr[nb] = p[i];
      nb++;
    end
    if (P_PAR[k] != 0) begin
      fr[nb] = pbit;
      nb++;
      perr = (((^p) ^ pbit) != (P_PAR[k] == 2));
    end
    for (int i = 0; i < P_STP[k]; i++) begin
      fr[nb] = stops[i];
      nb++;
      if (!stops[i]) ferr = 1'b1;
    end
    c0 = cyc;
    // Last stop sample sits half a bit into the final stop bit; valid follows one cycle later
    exp_q.push_back('{k, p, perr, ferr, c0 + 1 + LAT + cpb / 2 + (nb - 1) * cpb});
    for (int i = 0; i < nb; i++) begin
      line[k] = fr[i];
      repeat (cpb) @(negedge clk);
    end
    line[k] = 1'b1;
    g2 = gap;
    if (!stops[P_STP[k]-1] && g2 < cpb) g2 = cpb;
    repeat (g2) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    ev_t m;
    ev_t e;
    check({tag, " count"}, mon_q.size(), exp_q.size());
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mon_q.pop_front();
      check({tag, " inst"}, m.inst, e.inst);
      check({tag, " data"}, m.data, e.data);
      check({tag, " parity_err"}, m.perr, e.perr);
      check({tag, " frame_err"}, m.ferr, e.ferr);
      check({tag, " cycle"}, m.cyc, e.cyc);
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  initial begin
    int          r0;
    logic [7:0]  v55;
    logic [15:0] pay;
    logic [1:0]  st;
    logic        pb;
    v55 = 8'h55;
    for (int k = 0; k < NI; k++) line[k] = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset data%0d", k), w_data[k], 16'h0);
      check($sformatf("reset valid%0d", k), w_valid[k], 1'b0);
      check($sformatf("reset ready%0d", k), w_ready[k], 1'b1);
      check($sformatf("reset perr%0d", k), w_perr[k], 1'b0);
      check($sformatf("reset ferr%0d", k), w_ferr[k], 1'b0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    r0 = rdy_low[0];
    send_frame(0, 16'hA5, 1'b0, 2'b11, 4);
    repeat (32) @(negedge clk);
    check("a5 ready_low", rdy_low[0] - r0, 152);
    drain("a5");
    check("a5 hold", w_data[0], 16'hA5);

    r0 = rdy_low[0];
    line[0] = 1'b0;
    repeat (3) @(negedge clk);
    line[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch ready_low", rdy_low[0] - r0, 8);
    check("glitch ready", w_ready[0], 1'b1);
    drain("glitch");
    check("glitch hold", w_data[0], 16'hA5);

    send_frame(1, 16'h07, 1'b0, 2'b11, 0);
    send_frame(1, 16'h07, 1'b1, 2'b11, 8);
    repeat (32) @(negedge clk);
    drain("even parity");

    send_frame(2, 16'h3C, 1'b0, 2'b01, 0);
    repeat (32) @(negedge clk);
    drain("stop2");

    send_frame(3, 16'h1F, 1'b0, 2'b11, 0);
    send_frame(3, 16'h00, 1'b0, 2'b11, 0);
    send_frame(3, 16'h15, 1'b0, 2'b11, 8);
    repeat (32) @(negedge clk);
    drain("b2b");

    line[0] = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line[0] = v55[i];
      repeat (16) @(negedge clk);
    end
    line[0] = v55[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    line[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst data", w_data[0], 16'h0);
    check("midrst valid", w_valid[0], 1'b0);
    check("midrst ready", w_ready[0], 1'b1);
    check("midrst perr", w_perr[0], 1'b0);
    check("midrst ferr", w_ferr[0], 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(0, 16'h81, 1'b0, 2'b11, 4);
    repeat (32) @(negedge clk);
    drain("after reset");

    for (int k = 0; k < NI; k++) begin
      for (int f = 0; f < 8; f++) begin
        pay = 16'($urandom);
        pb  = 1'($urandom);
        st  = 2'b11;
        if ($urandom_range(0, 3) == 0) st = 2'($urandom);
        send_frame(k, pay, pb, st, int'($urandom_range(0, 3)));
      end
      repeat (2 * P_CPB[k]) @(negedge clk);
      drain($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame (legal 5..16).
REQ-002 Parameter CLK_PER_BIT, default 16, clk cycles per bit period (legal >= 4).
REQ-003 Parameter PARITY_MODE, default 0, 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked per frame (legal 1 or 2).
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 signal  input  1  serial RX line, idle high.
REQ-008 data  output  DATA_WIDTH  last received payload, LSB first on line.
REQ-009 valid  output  1  one-cycle pulse, data updated this cycle.
REQ-010 ready  output  1  high when FSM in IDLE, able to detect a new start bit.
REQ-011 parity_err  output  1  one-cycle pulse with valid when parity check fails.
REQ-012 frame_err  output  1  one-cycle pulse with valid when any stop bit samples 0.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_MODE = 0.
REQ-014 IDLE -> START SHALL occur on the first cycle the (conditioned) line reads 0; the bit counter clears.
REQ-015 START SHALL wait CLK_PER_BIT/2 cycles (integer division) then sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no output pulses).
REQ-016 DATA SHALL sample every CLK_PER_BIT cycles, shifting DATA_WIDTH bits LSB first into an internal register.
REQ-017 PARITY SHALL sample one bit CLK_PER_BIT cycles after the last data sample; even: XOR(payload, parity bit) must be 0; odd: must be 1.
REQ-018 STOP SHALL sample STOP_BITS bits at CLK_PER_BIT spacing; any 0 sample sets the frame error.
REQ-019 On the cycle after the last stop sample: data loads the shift register, valid = 1 for exactly one cycle, parity_err/frame_err reflect that frame, FSM returns to IDLE.
REQ-020 Data SHALL be delivered even when errors are flagged; data holds its value until the next valid.
REQ-021 Return to IDLE mid-stop-bit SHALL allow a start bit beginning half a bit period later to be received without loss (back-to-back frames).
REQ-022 No backpressure: valid is not gated by any input; a consumer missing the pulse loses the frame.
REQ-023 Bit-period counter width SHALL be $clog2(CLK_PER_BIT); it wraps to 0 on every sample.
REQ-024 ready SHALL be 0 in START, DATA, PARITY, STOP.

Reset
REQ-025 While rst_n = 0: FSM = IDLE, counters = 0, data = 0, valid = 0, parity_err = 0, frame_err = 0, ready = 1, synchroniser flops (if present) = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no valid pulse; after release, the next full frame SHALL be received correctly.

Configuration
REQ-027 Macro UART_RX_SYNC_EN defined: signal SHALL pass through a 2-flop synchroniser (reset to 1) before the FSM, adding 2 cycles of latency to every event.
REQ-028 UART_RX_SYNC_EN undefined: the FSM SHALL sample signal directly; all other behaviour is identical.

Verification
REQ-029 CLK_PER_BIT=16, DATA_WIDTH=8, no parity, send 0xA5 -> data=0xA5, valid high exactly 1 cycle, both errors 0.
REQ-030 Line low for 3 cycles then high -> ready low for 8 cycles then 1, no valid pulse.
REQ-031 PARITY_MODE=1, send 0x07 with parity bit 0 -> valid with parity_err=1, data=0x07; parity bit 1 -> parity_err=0.
REQ-032 STOP_BITS=2, second stop bit driven 0, payload 0x3C -> valid with frame_err=1, data=0x3C.
REQ-033 Assert rst_n low during data bit 4 of 0x55 -> outputs at reset values, no valid; then send 0x81 -> data=0x81, valid once.
REQ-034 DATA_WIDTH=5, frames 0x1F, 0x00, 0x15 back-to-back with no idle gap -> three valid pulses with those values in order, no errors.
